shift_register_universal: RTL and testbench

- Parametrised successor to the team's single-bit registered stage: a WIDTH-bit universal shift register.
- Supports hold, logical shift left/right with serial input, rotate left/right and parallel load.
- Adds a burst controller that performs a programmed number of shifts from one start pulse, with busy/done handshake.
- Sits between the serial link front-end and parallel datapath logic as a serialiser/deserialiser and barrel-by-steps element.

---
 rtl/shift_register_universal.sv | 149 ++++++++++++++
 tb/tb_shift_register_universal.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shift_register_universal.sv
// Universal WIDTH-bit shift register with a burst sequencer.
// Direct ops: hold, shift left/right with serial input, rotate left/right, parallel load.
// A start pulse with a shift/rotate mode runs that op shift_count times, with busy/done handshake.
//
// state | meaning
// IDLE  | applies the presented mode each enabled edge; accepts burst requests
// BURST | applies the latched mode each enabled edge until remaining reaches zero
module shift_register_universal #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_count,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;

    state_t             state;
    state_t             stateNext;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   remainingNext;
    logic [2:0]         latchedMode;
    logic [2:0]         latchedModeNext;
    logic [WIDTH-1:0]   dataNext;
    logic               serNext;
    logic               doneNext;

    logic [2:0]         opSel;
    logic [WIDTH-1:0]   opData;
    logic               opSer;
    logic               isShiftMode;

    // During a burst the latched mode drives the datapath; live mode is ignored.
    assign opSel       = (state == BURST) ? latchedMode : mode;
    assign isShiftMode = (mode >= MODE_SHL) && (mode <= MODE_ROR);
    assign busy        = (state == BURST);

    // Result of applying the selected operation to the current register contents.
    always_comb begin
        opData = data_out;
        opSer  = ser_out;
        case (opSel)
            MODE_SHL: begin
                opData = {data_out[WIDTH-2:0], ser_in};
                opSer  = data_out[WIDTH-1];
            end
            MODE_SHR: begin
                opData = {ser_in, data_out[WIDTH-1:1]};
                opSer  = data_out[0];
            end
            MODE_ROL: begin
                opData = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
                opSer  = data_out[WIDTH-1];
            end
            MODE_ROR: begin
                opData = {data_out[0], data_out[WIDTH-1:1]};
                opSer  = data_out[0];
            end
            MODE_LOAD: begin
                opData = load_data;
            end
            default: begin
                opData = data_out;
                opSer  = ser_out;
            end
        endcase
    end

    // Next-state, counter and handshake decisions; enable=0 leaves everything as is.
    always_comb begin
        stateNext       = state;
        remainingNext   = remaining;
        latchedModeNext = latchedMode;
        dataNext        = data_out;
        serNext         = ser_out;
        doneNext        = done;
        if (enable) begin
            doneNext = 1'b0;
            case (state)
                IDLE: begin
                    if (start && isShiftMode) begin
                        // The start edge itself never touches the data.
                        if (shift_count != '0) begin
                            latchedModeNext = mode;
                            remainingNext   = shift_count;
                            stateNext       = BURST;
                        end else begin
                            doneNext = 1'b1;
                        end
                    end else begin
                        dataNext = opData;
                        serNext  = opSer;
                    end
                end
                BURST: begin
                    dataNext      = opData;
                    serNext       = opSer;
                    remainingNext = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset taking priority over enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            remaining   <= '0;
            latchedMode <= 3'b000;
            data_out    <= '0;
            ser_out     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= stateNext;
            remaining   <= remainingNext;
            latchedMode <= latchedModeNext;
            data_out    <= dataNext;
            ser_out     <= serNext;
            done        <= doneNext;
        end
    end

endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal: directed vector table, then random stimulus vs. a reference model.
module tb_shift_register_universal;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [2:0]       mode;
    logic             ser_in;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic [CNT_W-1:0] shift_count;
    logic [WIDTH-1:0] data_out;
    logic             ser_out;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    shift_register_universal #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .mode(mode),
        .ser_in(ser_in),
        .load_data(load_data),
        .start(start),
        .shift_count(shift_count),
        .data_out(data_out),
        .ser_out(ser_out),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstN;
        logic       en;
        logic [2:0] md;
        logic       si;
        logic [7:0] ld;
        logic       st;
        logic [3:0] cnt;
        logic [7:0] eData;
        logic       eSer;
        logic       eBusy;
        logic       eDone;
    } vec_t;

    vec_t vq[$];

    task automatic addV(input logic rstN, input logic en, input logic [2:0] md, input logic si,
                        input logic [7:0] ld, input logic st, input logic [3:0] cnt,
                        input logic [7:0] eData, input logic eSer, input logic eBusy, input logic eDone);
        vec_t v;
        v.rstN = rstN; v.en = en; v.md = md; v.si = si; v.ld = ld; v.st = st; v.cnt = cnt;
        v.eData = eData; v.eSer = eSer; v.eBusy = eBusy; v.eDone = eDone;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eData, input logic eSer,
                         input logic eBusy, input logic eDone);
        total++;
        if (data_out !== eData || ser_out !== eSer || busy !== eBusy || done !== eDone) begin
            bad++;
            $display("FAIL %s: got data=%02h ser=%0b busy=%0b done=%0b, want data=%02h ser=%0b busy=%0b done=%0b",
                     name, data_out, ser_out, busy, done, eData, eSer, eBusy, eDone);
        end
    endtask

    // Reference model state: register contents, serial-out bit, pending burst shifts.
    int         mData;
    int         mSer;
    int         mDone;
    int         burstLeft;
    int         burstOp;

    function automatic void applyOp(input int op, input int si, input int ld);
        case (op)
            1: begin mSer = mData / 128; mData = (mData * 2 + si) % 256; end
            2: begin mSer = mData % 2;   mData = mData / 2 + si * 128; end
            3: begin mSer = mData / 128; mData = (mData * 2) % 256 + mData / 128; end
            4: begin mSer = mData % 2;   mData = mData / 2 + (mData % 2) * 128; end
            5: mData = ld;
            default: ;
        endcase
    endfunction

    function automatic void modelStep(input int rstN, input int en, input int md, input int si,
                                      input int ld, input int st, input int cnt);
        if (rstN == 0) begin
            mData = 0; mSer = 0; mDone = 0; burstLeft = 0; burstOp = 0;
        end else if (en != 0) begin
            mDone = 0;
            if (burstLeft > 0) begin
                applyOp(burstOp, si, ld);
                burstLeft--;
                if (burstLeft == 0) mDone = 1;
            end else if (st != 0 && md >= 1 && md <= 4) begin
                if (cnt == 0) mDone = 1;
                else begin
                    burstLeft = cnt;
                    burstOp   = md;
                end
            end else begin
                applyOp(md, si, ld);
            end
        end
    endfunction

    initial begin
        reset_n = 1'b1; enable = 1'b1; mode = 3'b001; ser_in = 1'b1;
        load_data = 8'hFF; start = 1'b1; shift_count = 4'hF;

        // reset, direct ops
        addV(0,1,3'd5,1,8'hFF,1,4'd7, 8'h00,0,0,0);
        addV(1,1,3'd5,0,8'hA5,0,4'd0, 8'hA5,0,0,0);
        addV(1,1,3'd1,1,8'h00,0,4'd0, 8'h4B,1,0,0);
        addV(1,1,3'd4,0,8'h00,0,4'd0, 8'hA5,1,0,0);
        addV(1,1,3'd7,0,8'h00,0,4'd0, 8'hA5,1,0,0);
        addV(0,0,3'd5,1,8'h33,1,4'd3, 8'h00,0,0,0);
        // rotate-left burst of 3
        addV(1,1,3'd5,0,8'h81,0,4'd0, 8'h81,0,0,0);
        addV(1,1,3'd3,0,8'h00,1,4'd3, 8'h81,0,1,0);
        addV(1,1,3'd0,1,8'h00,0,4'd0, 8'h03,1,1,0);
        addV(1,1,3'd5,0,8'hFF,1,4'd9, 8'h06,0,1,0);
        addV(1,1,3'd2,1,8'h00,0,4'd0, 8'h0C,0,0,1);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h0C,0,0,0);
        // shift-right deserialise of 8 with a 2-cycle stall
        addV(1,1,3'd2,0,8'h00,1,4'd8, 8'h0C,0,1,0);
        addV(1,1,3'd0,1,8'h00,0,4'd0, 8'h86,0,1,0);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h43,0,1,0);
        addV(1,0,3'd5,1,8'hFF,1,4'd1, 8'h43,0,1,0);
        addV(1,0,3'd1,1,8'hFF,0,4'd1, 8'h43,0,1,0);
        addV(1,1,3'd0,1,8'h00,0,4'd0, 8'hA1,1,1,0);
        addV(1,1,3'd0,1,8'h00,0,4'd0, 8'hD0,1,1,0);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h68,0,1,0);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h34,0,1,0);
        addV(1,1,3'd0,1,8'h00,0,4'd0, 8'h9A,0,1,0);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h4D,0,0,1);
        // back-to-back start during done, done held across a stall
        addV(1,1,3'd3,0,8'h00,1,4'd1, 8'h4D,0,1,0);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h9A,0,0,1);
        addV(1,0,3'd1,1,8'h00,0,4'd0, 8'h9A,0,0,1);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h9A,0,0,0);
        // zero count, start with load
        addV(1,1,3'd1,1,8'h00,1,4'd0, 8'h9A,0,0,1);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h9A,0,0,0);
        addV(1,1,3'd5,0,8'h3C,1,4'd3, 8'h3C,0,0,0);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h3C,0,0,0);
        // reset mid-burst
        addV(1,1,3'd1,0,8'h00,1,4'd5, 8'h3C,0,1,0);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h78,0,1,0);
        addV(0,1,3'd0,0,8'h00,0,4'd0, 8'h00,0,0,0);
        addV(1,1,3'd0,0,8'h00,0,4'd0, 8'h00,0,0,0);
        addV(1,1,3'd5,0,8'h5A,0,4'd0, 8'h5A,0,0,0);

        #2;
        for (int i = 0; i < vq.size(); i++) begin
            reset_n = vq[i].rstN; enable = vq[i].en; mode = vq[i].md; ser_in = vq[i].si;
            load_data = vq[i].ld; start = vq[i].st; shift_count = vq[i].cnt;
            tick();
            check($sformatf("vec%0d", i), vq[i].eData, vq[i].eSer, vq[i].eBusy, vq[i].eDone);
        end

        // Random phase against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int rN, en, md, si, ld, st, cnt;
            rN  = (i == 0) ? 0 : (($urandom_range(0, 63) == 0) ? 0 : 1);
            en  = ($urandom_range(0, 9) < 8) ? 1 : 0;
            md  = $urandom_range(0, 7);
            si  = $urandom_range(0, 1);
            ld  = $urandom_range(0, 255);
            st  = ($urandom_range(0, 5) == 0) ? 1 : 0;
            cnt = $urandom_range(0, 15);
            reset_n = rN[0]; enable = en[0]; mode = md[2:0]; ser_in = si[0];
            load_data = ld[7:0]; start = st[0]; shift_count = cnt[3:0];
            modelStep(rN, en, md, si, ld, st, cnt);
            tick();
            check($sformatf("rand%0d", i), mData[7:0], mSer[0], (burstLeft > 0), mDone[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
